line_buffer_pingpong: RTL and testbench
=======================================

LINE_BUFFER_PINGPONG -- requirements
Module: line_buffer_pingpong

Interface
REQ-001 SHALL have parameter H_RES, default 640, visible pixels per line.
REQ-002 SHALL have parameter COLOR_DEPTH, default 8, palette-index width.
REQ-003 SHALL have parameter X_W, default 10, pixel-coordinate width.
REQ-004 clk  input  1  pixel clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 line_swap  input  1  one-cycle pulse at scanline change; exchanges front/back banks.
REQ-007 wr_en  input  1  sprite-drawer pixel write strobe, back bank.
REQ-008 wr_x  input  X_W  write pixel column.
REQ-009 wr_color  input  COLOR_DEPTH  write palette index; 0 = transparent.
REQ-010 draw_done  input  1  drawer finished composing the back bank for the next line.
REQ-011 rd_de  input  1  display-enable from timing generator.
REQ-012 rd_x  input  X_W  read column (sx_next).
REQ-013 rd_color  output  COLOR_DEPTH  front-bank palette index, registered.
REQ-014 ready  output  1  high once the post-reset clear is finished.
REQ-015 back_bank  output  1  index of the bank currently writable.
REQ-016 overrun  output  1  sticky: swap occurred before draw_done.
REQ-017 overrun_clr  input  1  clears overrun.

Function
REQ-018 SHALL hold two banks of H_RES x COLOR_DEPTH storage, one front (read), one back (write).
REQ-019 SHALL implement FSM states CLEAR and RUN; reset enters CLEAR with clear counter = 0.
REQ-020 In CLEAR, SHALL write 0 to address counter in both banks each cycle, incrementing the counter; at counter = H_RES-1, next state RUN.
REQ-021 ready SHALL be 0 in CLEAR and 1 in RUN; ready first reads 1 on the edge H_RES cycles after rst deasserts.
REQ-022 In CLEAR, SHALL ignore wr_en, line_swap and rd_de; rd_color SHALL be 0.
REQ-023 In RUN, wr_en=1 with wr_x < H_RES and wr_color != 0 SHALL store wr_color at back[wr_x]; later writes to the same column overwrite earlier ones.
REQ-024 Writes with wr_color = 0 or wr_x >= H_RES SHALL be discarded.
REQ-025 Read: rd_color SHALL equal front[rd_x] one cycle after rd_de=1 with rd_x < H_RES; otherwise 0 one cycle later.
REQ-026 Read-clear: every qualifying read SHALL, in the same cycle, write 0 to front[rd_x] (read-before-clear), so the bank is empty when it returns as back bank.
REQ-027 line_swap=1 in RUN SHALL toggle back_bank at the end of that cycle; a write or read in the swap cycle SHALL target the pre-swap bank assignment.
REQ-028 If line_swap=1 in RUN while draw_done=0, overrun SHALL be set to 1; the swap still occurs.
REQ-029 overrun_clr=1 SHALL clear overrun; if set and clear coincide, set wins.
REQ-030 Back and front ports SHALL be independent: simultaneous write and read at the same column in different banks both complete.
REQ-031 Memories SHALL infer block RAM: one write port per bank, read-first on the front port.

Reset
REQ-032 On rst: state CLEAR, counter 0, back_bank 1, rd_color 0, ready 0, overrun 0.
REQ-033 rst asserted mid-RUN or mid-CLEAR SHALL restart the full clear sequence; prior contents are discarded.

Verification
REQ-034 Reset release, hold idle -> ready=0 for 640 cycles, then 1; all 640 reads of either bank return 0.
REQ-035 Write x=5 color 0x2A, x=5 color 0x11, x=6 color 0x00, then swap; read x=5,6 -> rd_color 0x11 then 0x00, each one cycle after request.
REQ-036 Write x=700 color 0xFF, swap, read all 640 columns -> all 0; repeat swap twice with no writes, read x=5 -> 0 (read-clear verified).
REQ-037 line_swap with draw_done=0 -> overrun=1, back_bank toggles; overrun_clr same cycle as another violating swap -> overrun stays 1; lone clear -> 0.
REQ-038 Write back[3]=0x07 in the same cycle as line_swap, then read x=3 next line -> 0x07; rd_de=0 with rd_x=3 -> rd_color 0, value retained.
REQ-039 rst pulsed after 100 RUN cycles with stored data -> ready drops for 640 cycles; afterwards all reads return 0, overrun=0.

Source files
------------

// File: rtl/line_buffer_pingpong.sv
// line_buffer_pingpong: ping-pong scanline buffer; back bank takes sprite writes, front bank is read and cleared.
module line_buffer_pingpong #(
  parameter int H_RES       = 640,
  parameter int COLOR_DEPTH = 8,
  parameter int X_W         = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_swap,
  input  logic                   wr_en,
  input  logic [X_W-1:0]         wr_x,
  input  logic [COLOR_DEPTH-1:0] wr_color,
  input  logic                   draw_done,
  input  logic                   rd_de,
  input  logic [X_W-1:0]         rd_x,
  output logic [COLOR_DEPTH-1:0] rd_color,
  output logic                   ready,
  output logic                   back_bank,
  output logic                   overrun,
  input  logic                   overrun_clr
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_d;
  logic [X_W-1:0] cnt, a0, a1;
  logic [COLOR_DEPTH-1:0] d0, d1, q0, q1;
  logic [COLOR_DEPTH-1:0] mem0 [H_RES];
  logic [COLOR_DEPTH-1:0] mem1 [H_RES];
  logic clr, wr_ok, rd_ok, we0, we1, rd_v, rd_b;
  assign clr   = state == CLEAR;
  assign ready = state == RUN;
  assign wr_ok = !clr && wr_en && int'(wr_x) < H_RES && |wr_color;
  assign rd_ok = !clr && rd_de && int'(rd_x) < H_RES;
  always_comb state_d = (clr && int'(cnt) == H_RES - 1) ? RUN : state;
  always_ff @(posedge clk) state <= rst ? CLEAR : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      back_bank <= 1'b1;
      overrun   <= 1'b0;
      rd_v      <= 1'b0;
      rd_b      <= 1'b0;
    end else begin
      cnt       <= clr ? cnt + 1'b1 : cnt;
      back_bank <= (!clr && line_swap) ? ~back_bank : back_bank;
      overrun   <= (!clr && line_swap && !draw_done) || (overrun && !overrun_clr);
      rd_v      <= rd_ok;
      rd_b      <= ~back_bank;
    end
  end
  // each bank owns one write port: clear sweep, sprite write when back, read-clear when front
  always_comb begin
    we0 = clr || (back_bank ? rd_ok : wr_ok);
    a0  = clr ? cnt : back_bank ? rd_x : wr_x;
    d0  = (clr || back_bank) ? '0 : wr_color;
    we1 = clr || (back_bank ? wr_ok : rd_ok);
    a1  = clr ? cnt : back_bank ? wr_x : rd_x;
    d1  = (clr || !back_bank) ? '0 : wr_color;
  end
  always_ff @(posedge clk) begin
    if (we0) mem0[a0] <= d0;
    q0 <= mem0[rd_x];
  end
  always_ff @(posedge clk) begin
    if (we1) mem1[a1] <= d1;
    q1 <= mem1[rd_x];
  end
  assign rd_color = rd_v ? (rd_b ? q1 : q0) : '0;
endmodule

// File: tb/tb_line_buffer_pingpong.sv
// tb_line_buffer_pingpong: scoreboard bench with a behavioural two-bank model.
module tb_line_buffer_pingpong;
  logic clk = 0, rst = 1, line_swap = 0, wr_en = 0, draw_done = 1, rd_de = 0, overrun_clr = 0;
  logic [9:0] wr_x = 0, rd_x = 0;
  logic [7:0] wr_color = 0, rd_color;
  logic ready, back_bank, overrun;
  int n_chk = 0, n_pass = 0;
  logic [7:0] mm [2][640];
  logic [7:0] sb [$];
  bit m_run = 0, m_bb = 1, m_ov = 0;
  int m_cnt = 0;
  always #5 clk = ~clk;
  line_buffer_pingpong dut (
    .clk(clk), .rst(rst), .line_swap(line_swap), .wr_en(wr_en), .wr_x(wr_x),
    .wr_color(wr_color), .draw_done(draw_done), .rd_de(rd_de), .rd_x(rd_x),
    .rd_color(rd_color), .ready(ready), .back_bank(back_bank), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask
  task automatic tick();
    logic [7:0] e;
    bit run_now;
    e = 0;
    run_now = m_run;
    if (rst) begin
      m_run = 0; m_cnt = 0; m_bb = 1; m_ov = 0;
    end else begin
      m_ov = (run_now && line_swap && !draw_done) ? 1'b1 : overrun_clr ? 1'b0 : m_ov;
      if (!run_now) begin
        mm[0][m_cnt] = 0; mm[1][m_cnt] = 0;
        m_cnt++;
        if (m_cnt == 640) m_run = 1;
      end else begin
        if (rd_de && rd_x < 640) begin
          e = mm[!m_bb][rd_x];
          mm[!m_bb][rd_x] = 0;
        end
        if (wr_en && wr_x < 640 && wr_color != 0) mm[m_bb][wr_x] = wr_color;
        if (line_swap) m_bb = !m_bb;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else chk("rd_color", rd_color, sb.pop_front());
    chk("ready", ready, m_run);
    chk("back_bank", back_bank, m_bb);
    chk("overrun", overrun, m_ov);
    rst = 0; line_swap = 0; wr_en = 0; rd_de = 0; overrun_clr = 0; draw_done = 1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic rd(input int x);
    rd_de = 1; rd_x = 10'(x); tick();
  endtask
  task automatic wr(input int x, input int c);
    wr_en = 1; wr_x = 10'(x); wr_color = 8'(c); tick();
  endtask
  task automatic swap(input bit dd);
    line_swap = 1; draw_done = dd; tick();
  endtask
  task automatic read_all();
    for (int x = 0; x < 640; x++) rd(x);
  endtask
  initial begin
    for (int b = 0; b < 2; b++) for (int x = 0; x < 640; x++) mm[b][x] = 0;
    rst = 1; tick(); rst = 1; tick(); rst = 1; tick();
    idle(645);
    read_all(); swap(1); read_all();
    wr(5, 'h2A); wr(5, 'h11); wr(6, 'h00); swap(1); rd(5); rd(6);
    wr(700, 'hFF); swap(1); read_all(); swap(1); swap(1); rd(5);
    swap(0);
    line_swap = 1; draw_done = 0; overrun_clr = 1; tick();
    overrun_clr = 1; tick();
    wr_en = 1; wr_x = 3; wr_color = 'h07; line_swap = 1; tick();
    rd_x = 3; rd_de = 0; tick();
    rd(3); rd(3);
    for (int i = 0; i < 600; i++) begin
      line_swap = ($urandom_range(0, 15) == 0);
      draw_done = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 7) == 0);
      wr_en = $urandom_range(0, 1);
      wr_x = 10'($urandom_range(0, 15) == 0 ? $urandom_range(640, 1023) : $urandom_range(0, 31));
      wr_color = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 255));
      rd_de = $urandom_range(0, 1);
      rd_x = 10'($urandom_range(0, 15) == 0 ? $urandom_range(640, 1023) : $urandom_range(0, 31));
      tick();
    end
    for (int x = 0; x < 40; x++) wr(x, x + 1);
    swap(0);
    idle(60);
    rst = 1; tick();
    wr(1, 'h55); swap(0); rd(1);
    idle(640);
    read_all(); swap(1); read_all();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
